// File: rtl/ramb4_arb_pkg.sv
// rtl/ramb4_arb_pkg.sv - shared types and read latency for the two-port RAMB4 arbiter
// Read latency is 3 when RAMB4_ARB_DOUT_REG_EN is defined, otherwise 2.
package ramb4_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2
  } owner_e;

  typedef logic req_id_t;

`ifdef RAMB4_ARB_DOUT_REG_EN
  localparam int unsigned RD_LAT = 3;
`else
  localparam int unsigned RD_LAT = 2;
`endif

endpackage

// File: rtl/ramb4_arb_rr2.sv
// rtl/ramb4_arb_rr2.sv - two-way round-robin winner, one-hot grant
// last_i is the requester granted most recently; the other one wins a tie.
module ramb4_arb_rr2
  import ramb4_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_t    last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ramb4_port_arb.sv
// rtl/ramb4_port_arb.sv - arbitrates two requesters onto one RAMB4 port, returns tagged read data
// RAMB4_ARB_DOUT_REG_EN adds one output register on DOUT/VLD (read latency 3).
module ramb4_port_arb
  import ramb4_arb_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] din0_i,
  output logic              gnt0_o,
  output logic              vld0_o,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] din1_i,
  output logic              gnt1_o,
  output logic              vld1_o,
  output logic [DATA_W-1:0] dout_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic              ram_rst_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_di_o,
  input  logic [DATA_W-1:0] ram_do_i
);

  logic              run_q;
  req_id_t           last_q, last_d;
  owner_e            state_q, state_d;
  logic [1:0]        win, gnt;
  logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_di_q, ram_di_d;
  logic [1:0]        vld_q, vld_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  ramb4_arb_rr2 u_rr2 (
    .req_i  ({req1_i, req0_i}),
    .last_i (last_q),
    .gnt_o  (win)
  );

  // run_q keeps grants off until the first edge after reset release
  assign gnt    = win & {2{run_q}};
  assign gnt0_o = gnt[0];
  assign gnt1_o = gnt[1];

  always_comb begin
    state_d    = IDLE;
    last_d     = last_q;
    ram_en_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_di_d   = ram_di_q;
    if (gnt[0]) begin
      state_d    = ACC0;
      last_d     = 1'b0;
      ram_en_d   = 1'b1;
      ram_we_d   = we0_i;
      ram_addr_d = addr0_i;
      ram_di_d   = din0_i;
    end else if (gnt[1]) begin
      state_d    = ACC1;
      last_d     = 1'b1;
      ram_en_d   = 1'b1;
      ram_we_d   = we1_i;
      ram_addr_d = addr1_i;
      ram_di_d   = din1_i;
    end
  end

  // The owner state during the RAM cycle tags the data that appears on RAM_DO next cycle
  assign vld_d  = {(state_q == ACC1) && !ram_we_q, (state_q == ACC0) && !ram_we_q};
  assign dout_d = (|vld_q) ? ram_do_i : dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      last_q     <= 1'b1;
      state_q    <= IDLE;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_di_q   <= '0;
      vld_q      <= 2'b00;
      dout_q     <= '0;
    end else begin
      run_q      <= 1'b1;
      last_q     <= last_d;
      state_q    <= state_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_di_q   <= ram_di_d;
      vld_q      <= vld_d;
      dout_q     <= dout_d;
    end
  end

  if (RD_LAT > 2) begin : g_dout_reg
    logic [1:0] vld_out_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_out_q <= 2'b00;
      else        vld_out_q <= vld_q;
    end
    assign vld0_o = vld_out_q[0];
    assign vld1_o = vld_out_q[1];
    assign dout_o = dout_q;
  end else begin : g_dout_comb
    assign vld0_o = vld_q[0];
    assign vld1_o = vld_q[1];
    assign dout_o = dout_d;
  end

  assign ram_en_o   = ram_en_q;
  assign ram_we_o   = ram_we_q;
  assign ram_rst_o  = 1'b0;
  assign ram_addr_o = ram_addr_q;
  assign ram_di_o   = ram_di_q;

endmodule

// File: tb/tb_ramb4_port_arb.sv
// tb/tb_ramb4_port_arb.sv - table-driven bench for ramb4_port_arb with a behavioural RAMB4 port
module tb_ramb4_port_arb;

`ifdef RAMB4_ARB_DOUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int NV = 26;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0, we0, req1, we1;
  logic [8:0] addr0, addr1;
  logic [7:0] din0, din1;
  logic       gnt0, gnt1, vld0, vld1;
  logic [7:0] dout;
  logic       ram_en, ram_we, ram_rst;
  logic [8:0] ram_addr;
  logic [7:0] ram_di, ram_do;

  always #5 clk = ~clk;

  ramb4_port_arb #(.ADDR_W(9), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .din0_i(din0), .gnt0_o(gnt0), .vld0_o(vld0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .din1_i(din1), .gnt1_o(gnt1), .vld1_o(vld1),
    .dout_o(dout), .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_rst_o(ram_rst),
    .ram_addr_o(ram_addr), .ram_di_o(ram_di), .ram_do_i(ram_do)
  );

  function automatic logic [7:0] init_val(input int a);
    case (a)
      'h005: return 8'hA5;
      'h010: return 8'h11;
      'h020: return 8'h22;
      'h021: return 8'h2A;
      'h022: return 8'h2B;
      'h030: return 8'h33;
      'h031: return 8'h3B;
      'h040: return 8'h44;
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0] mem [512];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
      ram_do <= 8'h00;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      ram_do <= mem[ram_addr];
    end
  end

  typedef struct {
    logic       r0, w0; logic [8:0] a0; logic [7:0] d0;
    logic       r1, w1; logic [8:0] a1; logic [7:0] d1;
    logic       g0, g1;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs [NV];
  int   nvec = 0;
  int   nerr = 0;

  logic       e_en [64], e_we [64], e_v0 [64], e_v1 [64];
  logic [8:0] e_addr [64];
  logic [7:0] e_di [64], e_rd [64];
  logic [8:0] cur_addr = '0;
  logic [7:0] cur_di = '0, cur_dout = '0;

  function automatic vec_t mk(input logic r0, w0, input logic [8:0] a0, input logic [7:0] d0,
                              input logic r1, w1, input logic [8:0] a1, input logic [7:0] d1,
                              input logic g0, g1, input logic [7:0] rd);
    vec_t v;
    v = '{r0, w0, a0, d0, r1, w1, a1, d1, g0, g1, rd};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; din0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; din1 = v.d1;
  endtask

  task automatic step(input int c, input vec_t v);
    @(posedge clk); #1;
    drive(v);
    #3;
    chk($sformatf("c%0d gnt0", c), gnt0, v.g0);
    chk($sformatf("c%0d gnt1", c), gnt1, v.g1);
    if (e_en[c]) begin cur_addr = e_addr[c]; cur_di = e_di[c]; end
    chk($sformatf("c%0d ram_en", c), ram_en, e_en[c]);
    chk($sformatf("c%0d ram_we", c), ram_we, e_we[c]);
    chk($sformatf("c%0d ram_addr", c), ram_addr, cur_addr);
    chk($sformatf("c%0d ram_di", c), ram_di, cur_di);
    chk($sformatf("c%0d ram_rst", c), ram_rst, 1'b0);
    if (e_v0[c] || e_v1[c]) cur_dout = e_rd[c];
    chk($sformatf("c%0d vld0", c), vld0, e_v0[c]);
    chk($sformatf("c%0d vld1", c), vld1, e_v1[c]);
    chk($sformatf("c%0d dout", c), dout, cur_dout);
    if (v.g0) begin
      e_en[c+1] = 1'b1; e_we[c+1] = v.w0; e_addr[c+1] = v.a0; e_di[c+1] = v.d0;
      if (!v.w0) begin e_v0[c+LAT] = 1'b1; e_rd[c+LAT] = v.rd; end
    end else if (v.g1) begin
      e_en[c+1] = 1'b1; e_we[c+1] = v.w1; e_addr[c+1] = v.a1; e_di[c+1] = v.d1;
      if (!v.w1) begin e_v1[c+LAT] = 1'b1; e_rd[c+LAT] = v.rd; end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " gnt0"}, gnt0, 1'b0);
    chk({tag, " gnt1"}, gnt1, 1'b0);
    chk({tag, " vld0"}, vld0, 1'b0);
    chk({tag, " vld1"}, vld1, 1'b0);
    chk({tag, " ram_en"}, ram_en, 1'b0);
    chk({tag, " ram_we"}, ram_we, 1'b0);
    chk({tag, " ram_rst"}, ram_rst, 1'b0);
    chk({tag, " ram_addr"}, ram_addr, 9'h000);
    chk({tag, " ram_di"}, ram_di, 8'h00);
    chk({tag, " dout"}, dout, 8'h00);
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,9'h000,8'h00, 0,0,9'h000,8'h00, 0,0,8'h00);
    for (int i = 0; i < NV; i++) vecs[i] = idle;
    vecs[0]  = mk(1,0,9'h005,8'h00, 0,0,9'h000,8'h00, 1,0,8'hA5);
    vecs[4]  = mk(1,1,9'h1FF,8'h3C, 0,0,9'h000,8'h00, 1,0,8'h00);
    vecs[5]  = mk(1,0,9'h1FF,8'h00, 0,0,9'h000,8'h00, 1,0,8'h3C);
    vecs[9]  = mk(0,0,9'h000,8'h00, 1,0,9'h010,8'h00, 0,1,8'h11);
    vecs[10] = mk(1,0,9'h020,8'h00, 1,0,9'h030,8'h00, 1,0,8'h22);
    vecs[11] = mk(1,0,9'h021,8'h00, 1,0,9'h030,8'h00, 0,1,8'h33);
    vecs[12] = mk(1,0,9'h021,8'h00, 1,0,9'h031,8'h00, 1,0,8'h2A);
    vecs[13] = mk(1,0,9'h022,8'h00, 1,0,9'h031,8'h00, 0,1,8'h3B);
    vecs[17] = mk(1,0,9'h040,8'h00, 1,1,9'h040,8'h77, 1,0,8'h44);
    vecs[18] = mk(0,0,9'h000,8'h00, 1,1,9'h040,8'h77, 0,1,8'h00);
    vecs[19] = mk(1,0,9'h040,8'h00, 0,0,9'h000,8'h00, 1,0,8'h77);
    vecs[20] = mk(1,1,9'h005,8'h5A, 1,0,9'h030,8'h00, 0,1,8'h33);
    vecs[21] = mk(1,1,9'h005,8'h5A, 0,0,9'h000,8'h00, 1,0,8'h00);
    for (int i = 0; i < 64; i++) begin
      e_en[i] = 0; e_we[i] = 0; e_v0[i] = 0; e_v1[i] = 0;
      e_addr[i] = '0; e_di[i] = '0; e_rd[i] = '0;
    end

    drive(idle);
    req0 = 1'b1; addr0 = 9'h005;
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    chk("release gnt0", gnt0, 1'b0);
    req0 = 1'b0;

    for (int c = 0; c < NV; c++) step(c, vecs[c]);

    @(posedge clk); #1;
    drive(idle);
    req0 = 1'b1; addr0 = 9'h005;
    #3;
    chk("mid gnt0", gnt0, 1'b1);
    @(posedge clk); #1;
    req0 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid rst");
    req0 = 1'b1; addr0 = 9'h010;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #4;
      chk_all_zero($sformatf("hold rst %0d", k));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    chk("rel gnt0", gnt0, 1'b0);
    chk("rel vld0", vld0, 1'b0);
    @(posedge clk); #4;
    chk("post gnt0", gnt0, 1'b1);
    chk("post vld0", vld0, 1'b0);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk); #1;
      req0 = 1'b0;
      #3;
      if (k == 1) begin
        chk("post ram_en", ram_en, 1'b1);
        chk("post ram_addr", ram_addr, 9'h010);
      end
      chk($sformatf("post vld0 +%0d", k), vld0, (k == LAT));
      chk($sformatf("post vld1 +%0d", k), vld1, 1'b0);
      chk($sformatf("post dout +%0d", k), dout, (k >= LAT) ? 8'h11 : 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
